// File: rtl/kersram_r.sv
`default_nettype none
// ============================================================================
// Module   : kersram_r
// Purpose  : Kernel SRAM read sequencer. Reads eight kernel SRAM banks in
//            lock-step and streams 8x64-bit slices over valid/ready, replaying
//            the kernel a programmable number of passes.
// Revision : 1.0 - initial release
// ============================================================================
module kersram_r #(
    parameter int ADDR_CNT_BITS = 10,
    parameter int KER_ST_LENGTH = 288,
    parameter int REPEAT_BITS   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_ker_read,
    input  logic [REPEAT_BITS-1:0]   ker_repeat_num,
    output logic                     ker_read_busy,
    output logic                     ker_read_done,
    output logic                     cen_kersr_0,
    output logic                     cen_kersr_1,
    output logic                     cen_kersr_2,
    output logic                     cen_kersr_3,
    output logic                     cen_kersr_4,
    output logic                     cen_kersr_5,
    output logic                     cen_kersr_6,
    output logic                     cen_kersr_7,
    output logic                     wen_kersr_0,
    output logic                     wen_kersr_1,
    output logic                     wen_kersr_2,
    output logic                     wen_kersr_3,
    output logic                     wen_kersr_4,
    output logic                     wen_kersr_5,
    output logic                     wen_kersr_6,
    output logic                     wen_kersr_7,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_0,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_1,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_2,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_3,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_4,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_5,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_6,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_7,
    input  logic [63:0]              dout_kersr_0,
    input  logic [63:0]              dout_kersr_1,
    input  logic [63:0]              dout_kersr_2,
    input  logic [63:0]              dout_kersr_3,
    input  logic [63:0]              dout_kersr_4,
    input  logic [63:0]              dout_kersr_5,
    input  logic [63:0]              dout_kersr_6,
    input  logic [63:0]              dout_kersr_7,
    output logic [63:0]              ker_data_0,
    output logic [63:0]              ker_data_1,
    output logic [63:0]              ker_data_2,
    output logic [63:0]              ker_data_3,
    output logic [63:0]              ker_data_4,
    output logic [63:0]              ker_data_5,
    output logic [63:0]              ker_data_6,
    output logic [63:0]              ker_data_7,
    output logic                     ker_data_valid,
    input  logic                     ker_data_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_CNT_BITS-1:0] LAST_ADDR = ADDR_CNT_BITS'(KER_ST_LENGTH - 1);

    state_t                   state;
    logic [ADDR_CNT_BITS-1:0] addr_cnt;
    logic [ADDR_CNT_BITS-1:0] addr_hold;
    logic [REPEAT_BITS-1:0]   pass_cnt;
    logic [REPEAT_BITS-1:0]   pass_tot;
    logic                     inflight;
    logic [1:0]               occ;
    logic [511:0]             head;
    logic [511:0]             tail;
    logic [511:0]             rd_word;
    logic [2:0]               pending;
    logic                     pop;
    logic                     issue;
    logic                     last_issue;
    logic                     start_acc;

    // All eight banks are read together; bank k occupies bits [64k+63:64k].
    assign rd_word = {dout_kersr_7, dout_kersr_6, dout_kersr_5, dout_kersr_4,
                      dout_kersr_3, dout_kersr_2, dout_kersr_1, dout_kersr_0};

    assign start_acc  = (state == S_IDLE) && start_ker_read;
    assign pop        = ker_data_valid & ker_data_ready;
    // Entries that will be held after this cycle if no new read is issued.
    assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == S_READ) && (pending < 3'd2);
    assign last_issue = issue && (addr_cnt == LAST_ADDR)
                        && (pass_cnt == pass_tot - REPEAT_BITS'(1));

    assign cen_kersr_0 = ~issue;
    assign cen_kersr_1 = ~issue;
    assign cen_kersr_2 = ~issue;
    assign cen_kersr_3 = ~issue;
    assign cen_kersr_4 = ~issue;
    assign cen_kersr_5 = ~issue;
    assign cen_kersr_6 = ~issue;
    assign cen_kersr_7 = ~issue;

    assign wen_kersr_0 = 1'b1;
    assign wen_kersr_1 = 1'b1;
    assign wen_kersr_2 = 1'b1;
    assign wen_kersr_3 = 1'b1;
    assign wen_kersr_4 = 1'b1;
    assign wen_kersr_5 = 1'b1;
    assign wen_kersr_6 = 1'b1;
    assign wen_kersr_7 = 1'b1;

    // Address shows the live counter while issuing and the last issued value otherwise.
    logic [ADDR_CNT_BITS-1:0] addr_out;
    assign addr_out     = issue ? addr_cnt : addr_hold;
    assign addr_kersr_0 = addr_out;
    assign addr_kersr_1 = addr_out;
    assign addr_kersr_2 = addr_out;
    assign addr_kersr_3 = addr_out;
    assign addr_kersr_4 = addr_out;
    assign addr_kersr_5 = addr_out;
    assign addr_kersr_6 = addr_out;
    assign addr_kersr_7 = addr_out;

    assign ker_data_valid = (occ != 2'd0);
    assign ker_data_0     = head[ 63:  0];
    assign ker_data_1     = head[127: 64];
    assign ker_data_2     = head[191:128];
    assign ker_data_3     = head[255:192];
    assign ker_data_4     = head[319:256];
    assign ker_data_5     = head[383:320];
    assign ker_data_6     = head[447:384];
    assign ker_data_7     = head[511:448];

    // Control FSM with registered busy/done flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            pass_tot      <= '0;
            ker_read_busy <= 1'b0;
            ker_read_done <= 1'b0;
        end else begin
            ker_read_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ker_read) begin
                        pass_tot      <= (ker_repeat_num == '0) ? REPEAT_BITS'(1) : ker_repeat_num;
                        state         <= S_READ;
                        ker_read_busy <= 1'b1;
                    end
                end
                S_READ: begin
                    if (last_issue) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave once the final beat is being (or has been) handed off.
                    if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                        state         <= S_DONE;
                        ker_read_busy <= 1'b0;
                        ker_read_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state         <= S_IDLE;
                    ker_read_busy <= 1'b0;
                end
            endcase
        end
    end

    // Address and pass counters advance on each issued read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt  <= '0;
            addr_hold <= '0;
            pass_cnt  <= '0;
        end else if (start_acc) begin
            addr_cnt <= '0;
            pass_cnt <= '0;
        end else if (issue) begin
            addr_hold <= addr_cnt;
            if (addr_cnt == LAST_ADDR) begin
                addr_cnt <= '0;
                pass_cnt <= pass_cnt + REPEAT_BITS'(1);
            end else begin
                addr_cnt <= addr_cnt + ADDR_CNT_BITS'(1);
            end
        end
    end

    // Two-entry output FIFO: capture SRAM data the cycle after an issue, pop on handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= issue;
            if (start_acc) begin
                occ <= 2'd0;
            end else begin
                case ({inflight, pop})
                    2'b11: begin
                        if (occ == 2'd2) begin
                            head <= tail;
                            tail <= rd_word;
                        end else begin
                            head <= rd_word;
                        end
                    end
                    2'b01: begin
                        head <= tail;
                        occ  <= occ - 2'd1;
                    end
                    2'b10: begin
                        if (occ == 2'd0) begin
                            head <= rd_word;
                        end else begin
                            tail <= rd_word;
                        end
                        occ <= occ + 2'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kersram_r.sv
`default_nettype none
// ============================================================================
// Module   : tb_kersram_r
// Purpose  : Scoreboard bench for kersram_r with a behavioural SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kersram_r;

    localparam int AW  = 10;
    localparam int LEN = 288;
    localparam int RB  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [RB-1:0] rep = '0;
    logic          busy, done, valid;
    logic          cen [8];
    logic          wen [8];
    logic [AW-1:0] addr [8];
    logic [63:0]   dout [8];
    logic [63:0]   kd [8];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int issued = 0;
    int popped = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_hs = -10;
    int rmode = 0;
    int rpat_idx = 0;
    int exp_q [$];

    always #5 clk = ~clk;

    kersram_r #(.ADDR_CNT_BITS(AW), .KER_ST_LENGTH(LEN), .REPEAT_BITS(RB)) dut (
        .clk(clk), .reset(reset), .start_ker_read(start), .ker_repeat_num(rep),
        .ker_read_busy(busy), .ker_read_done(done),
        .cen_kersr_0(cen[0]), .cen_kersr_1(cen[1]), .cen_kersr_2(cen[2]), .cen_kersr_3(cen[3]),
        .cen_kersr_4(cen[4]), .cen_kersr_5(cen[5]), .cen_kersr_6(cen[6]), .cen_kersr_7(cen[7]),
        .wen_kersr_0(wen[0]), .wen_kersr_1(wen[1]), .wen_kersr_2(wen[2]), .wen_kersr_3(wen[3]),
        .wen_kersr_4(wen[4]), .wen_kersr_5(wen[5]), .wen_kersr_6(wen[6]), .wen_kersr_7(wen[7]),
        .addr_kersr_0(addr[0]), .addr_kersr_1(addr[1]), .addr_kersr_2(addr[2]), .addr_kersr_3(addr[3]),
        .addr_kersr_4(addr[4]), .addr_kersr_5(addr[5]), .addr_kersr_6(addr[6]), .addr_kersr_7(addr[7]),
        .dout_kersr_0(dout[0]), .dout_kersr_1(dout[1]), .dout_kersr_2(dout[2]), .dout_kersr_3(dout[3]),
        .dout_kersr_4(dout[4]), .dout_kersr_5(dout[5]), .dout_kersr_6(dout[6]), .dout_kersr_7(dout[7]),
        .ker_data_0(kd[0]), .ker_data_1(kd[1]), .ker_data_2(kd[2]), .ker_data_3(kd[3]),
        .ker_data_4(kd[4]), .ker_data_5(kd[5]), .ker_data_6(kd[6]), .ker_data_7(kd[7]),
        .ker_data_valid(valid), .ker_data_ready(ready)
    );

    // Contents of bank k at address a.
    function automatic logic [63:0] word(input int k, input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        return {8'(8'hB0 + k), 8'(8'h5A ^ k), a16, ~a16, 16'(a * 3 + k)};
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SRAM model: one-cycle read latency per bank.
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (!cen[k]) dout[k] <= word(k, int'(addr[k]));
        end
    end

    // Ready generator: 0 = held high, 1 = 1,0,0,1 pattern with random flips, 2 = held low.
    always @(posedge clk) begin
        logic [3:0] pat;
        #1;
        pat = 4'b1001;
        case (rmode)
            0: ready = 1'b1;
            1: begin
                ready = pat[rpat_idx % 4] ^ ($urandom_range(0, 3) == 0);
                rpat_idx++;
            end
            default: ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        bit ok;
        bit pop_now;
        int a;
        cyc++;
        if (!reset) begin
            issued = 0;
            popped = 0;
        end else begin
            pop_now = valid && ready;
            ok = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (cen[k] !== cen[0] || addr[k] !== addr[0] || wen[k] !== 1'b1) ok = 1'b0;
            end
            chk(ok, "bank_uniform", {63'd0, cen[0]}, {63'd0, cen[7]});
            if (cen[0] === 1'b0) begin
                chk((issued - popped - int'(pop_now)) < 2, "issue_bound", 64'(issued - popped), 64'd1);
                issued++;
            end
            if (busy) chk(!(dut.inflight && dut.occ == 2'd2), "capture_full", 64'(dut.occ), 64'd1);
            if (pop_now) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_beat", kd[0], 64'd0);
                end else begin
                    a = exp_q.pop_front();
                    ok = 1'b1;
                    for (int k = 0; k < 8; k++) if (kd[k] !== word(k, a)) ok = 1'b0;
                    chk(ok, $sformatf("beat_data@%0d", a), kd[0], word(0, a));
                end
                popped++;
                last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk(cyc == last_hs + 1, "done_timing", 64'(cyc), 64'(last_hs + 1));
                chk(!busy, "busy_at_done", {63'd0, busy}, 64'd0);
                chk(exp_q.size() == 0, "beats_left_at_done", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    task automatic push_beats(input int r);
        int np;
        np = (r == 0) ? 1 : r;
        for (int p = 0; p < np; p++)
            for (int a = 0; a < LEN; a++) exp_q.push_back(a);
    endtask

    // Start pulse; s is the negedge index of the cycle start is presented in.
    task automatic do_start(input int r, output int s);
        push_beats(r);
        rep = RB'(r);
        start = 1'b1;
        s = cyc + 1;
        tick();
        start = 1'b0;
        rep = RB'($urandom);
    endtask

    task automatic wait_done(input int bound, input string name);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < bound) begin
            tick();
            i++;
        end
        chk(done_cnt == d0 + 1, name, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        bit ok;
        ok = !valid && !busy && !done;
        for (int k = 0; k < 8; k++)
            if (cen[k] !== 1'b1 || wen[k] !== 1'b1 || addr[k] !== '0 || kd[k] !== '0) ok = 1'b0;
        chk(ok, name, {61'd0, valid, busy, done}, 64'd0);
    endtask

    initial begin
        int s;
        int d0;
        int i0;
        int p0;
        bit ok;

        // Reset state
        #2;
        check_reset_outputs("reset_state");
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // Test 1: single pass, ready high, latency checks
        rmode = 0;
        push_beats(1);
        rep = 8'd1;
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        #1;
        chk(!valid && cen[0] && !busy, "t1_start_cycle", {61'd0, valid, cen[0], busy}, 64'b010);
        tick();
        start = 1'b0;
        rep = 8'd7;
        @(negedge clk);
        #1;
        chk(!cen[0] && addr[0] == '0, "t1_first_issue", {53'd0, cen[0], addr[0]}, 64'd0);
        chk(busy && !valid, "t1_busy_rise", {62'd0, busy, valid}, 64'b10);
        @(negedge clk);
        #1;
        chk(!valid, "t1_valid_early", {63'd0, valid}, 64'd0);
        @(negedge clk);
        #1;
        chk(valid, "t1_first_valid", {63'd0, valid}, 64'd1);
        wait_done(LEN + 50, "t1_done");
        chk(done_cyc - s == LEN + 3, "t1_throughput", 64'(done_cyc - s), 64'(LEN + 3));
        repeat (3) tick();
        chk(!busy && !valid && !done, "t1_idle_after", {61'd0, busy, valid, done}, 64'd0);

        // Test 2: three passes, no gaps across pass boundaries
        do_start(3, s);
        wait_done(3 * LEN + 50, "t2_done");
        chk(done_cyc - s == 3 * LEN + 3, "t2_throughput", 64'(done_cyc - s), 64'(3 * LEN + 3));
        repeat (3) tick();

        // Test 3: two passes under irregular backpressure
        rmode = 1;
        do_start(2, s);
        wait_done(8 * LEN + 50, "t3_done");
        chk(exp_q.size() == 0, "t3_all_beats", 64'(exp_q.size()), 64'd0);
        rmode = 0;
        repeat (3) tick();

        // Test 4: repeat=0 behaves as one pass; start while busy ignored
        d0 = done_cnt;
        do_start(0, s);
        repeat (50) tick();
        rep = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(LEN + 50, "t4_done");
        chk(done_cyc - s == LEN + 3, "t4_one_pass", 64'(done_cyc - s), 64'(LEN + 3));
        repeat (20) tick();
        chk(done_cnt == d0 + 1 && !busy && !valid, "t4_no_extra",
            64'(done_cnt - d0), 64'd1);

        // Test 5: reset at beat 100 aborts, fresh start replays
        d0 = done_cnt;
        p0 = popped;
        do_start(1, s);
        for (int i = 0; i < 400 && popped < p0 + 100; i++) tick();
        chk(popped == p0 + 100, "t5_reach_beat100", 64'(popped - p0), 64'd100);
        reset = 1'b0;
        #1;
        check_reset_outputs("t5_async_reset");
        exp_q.delete();
        repeat (3) tick();
        check_reset_outputs("t5_reset_held");
        reset = 1'b1;
        repeat (5) tick();
        chk(done_cnt == d0 && !busy, "t5_no_done", 64'(done_cnt - d0), 64'd0);
        do_start(1, s);
        wait_done(LEN + 50, "t5_replay_done");
        chk(done_cyc - s == LEN + 3, "t5_replay_len", 64'(done_cyc - s), 64'(LEN + 3));
        repeat (3) tick();

        // Test 6: ready low from start, then release
        rmode = 2;
        tick();
        i0 = issued;
        do_start(1, s);
        repeat (10) tick();
        chk(issued - i0 == 2, "t6_two_reads", 64'(issued - i0), 64'd2);
        ok = valid;
        for (int k = 0; k < 8; k++) if (kd[k] !== word(k, 0)) ok = 1'b0;
        chk(ok, "t6_beat0_held", kd[0], word(0, 0));
        repeat (10) tick();
        ok = valid;
        for (int k = 0; k < 8; k++) if (kd[k] !== word(k, 0)) ok = 1'b0;
        chk(ok, "t6_beat0_stable", kd[0], word(0, 0));
        chk(issued - i0 == 2, "t6_still_two", 64'(issued - i0), 64'd2);
        rmode = 0;
        wait_done(LEN + 50, "t6_done");
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/kersram_r.md
# kersram_r

Kernel SRAM read sequencer, the stage directly downstream of the kernel SRAM write controller. It reads the eight kernel SRAM banks in lock-step, one 64-bit word per bank per address. It streams the resulting 8×64-bit kernel slice to the compute array over a valid/ready handshake. Kernels are replayed a programmable number of passes for weight reuse, and a 2-entry output buffer absorbs the 1-cycle SRAM read latency under backpressure.

## Interface
- ADDR_CNT_BITS, 10, SRAM address width.
- KER_ST_LENGTH, 288, words per bank per pass.
- REPEAT_BITS, 8, width of pass-count input.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start_ker_read  in  1  start pulse; sampled only in IDLE.
- ker_repeat_num  in  REPEAT_BITS  number of passes, latched at start; 0 is treated as 1.
- ker_read_busy  out  1  high from the cycle after an accepted start until done.
- ker_read_done  out  1  one-cycle completion pulse.
- cen_kersr_k (k=0..7)  out  1  SRAM chip enable, active-low; identical on all banks.
- wen_kersr_k (k=0..7)  out  1  SRAM write enable, active-low; tied 1 (read only).
- addr_kersr_k (k=0..7)  out  ADDR_CNT_BITS  read address; identical on all banks.
- dout_kersr_k (k=0..7)  in  64  SRAM read data, valid 1 cycle after cen low.
- ker_data_k (k=0..7)  out  64  output slice, bank k, from buffer head.
- ker_data_valid  out  1  buffer non-empty.
- ker_data_ready  in  1  consumer accepts the head when valid & ready.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE→READ when start_ker_read=1. On that edge:
  - latch pass_tot = max(ker_repeat_num, 1);
  - clear the address counter, pass counter and buffer.
- In READ, a read is issued in a cycle when (occ + inflight − pop) < 2:
  - occ = buffer entries (0..2);
  - inflight = 1 if a read was issued in the previous cycle;
  - pop = ker_data_valid & ker_data_ready.
- Issue means cen_kersr_k=0 and addr_kersr_k = address counter, after which the counter increments.
- Address counter: when the counter = KER_ST_LENGTH−1 and issues, it wraps to 0 and the pass counter increments.
- READ→DRAIN on the issue of the last address of the last pass.
- DRAIN→DONE when occ=0, inflight=0 and the last beat has been popped.
- DONE→IDLE unconditionally. ker_read_done=1 in DONE only.
- Capture: dout_kersr_0..7 is written into the buffer tail in the cycle after an issue, as one 512-bit entry. The buffer is a FIFO, head first.
- Simultaneous capture and pop is legal; occupancy is then unchanged.
- Capture with occ=2 cannot occur by construction. Verification asserts this.
- cen_kersr_k stays 1 when no read is issued. Addresses hold the last value when cen is high.
- start_ker_read outside IDLE is ignored. ker_repeat_num changes while busy have no effect.
- Total beats delivered = KER_ST_LENGTH × pass_tot. Order: address 0..KER_ST_LENGTH−1, repeated per pass.
- Counter widths: address counter uses ADDR_CNT_BITS; pass counter uses REPEAT_BITS; no overflow is possible.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state to IDLE; all counters and occupancy to 0;
  - cen_kersr_k=1, wen_kersr_k=1, addr_kersr_k=0;
  - ker_data_k=0, ker_data_valid=0, ker_read_busy=0, ker_read_done=0.
- Reset mid-operation aborts the transfer: no done pulse, and buffered data is discarded.
- Start accepted at edge E0; READ is active from E0.
  - First cen low in the cycle after E0.
  - Data is captured at the next edge.
  - ker_data_valid goes high 2 cycles after the first cen low, i.e. 3 cycles after start is sampled.
- With ker_data_ready held 1, throughput is 1 beat/cycle, with no bubbles across pass boundaries.
- ker_read_done pulses in the cycle after the last handshake. ker_read_busy falls in the same cycle as the done pulse; busy is 1 in READ and DRAIN only.
- ker_data_k and ker_data_valid are registered (buffer outputs). There are no combinational paths from ker_data_ready to the data outputs.
- cen may depend combinationally on ker_data_ready through pop.

## Test plan
- Single pass, ready=1, repeat=1: start → addr 0..287 on 288 consecutive cycles. Valid is first seen 3 cycles after start. Beat n carries bank-k word n. Done pulses 1 cycle after beat 287, and busy falls with it.
- repeat=3, ready=1 → 864 beats with no gap; the address wraps 287→0 twice; one done pulse.
- ready toggling 1,0,0,1 pseudo-random, repeat=2 → exactly 576 beats in order, with no duplicates or drops. cen stays high whenever occ+inflight=2 with no pop. The capture-into-full assertion never fires.
- repeat=0 → behaves as 1 pass (288 beats). A start pulse during busy is ignored, giving no extra beats or done.
- reset low at beat 100 of pass 1 → all outputs take their reset values immediately. A fresh start then replays from address 0 with full 288-beat output.
- ready=0 from start → exactly 2 reads issued, valid held high with beat 0 stable. On release, beats 0..287 are delivered in order.
